simd_vector_core: RTL
=====================

Name: simd_vector_core

Overview:
- Parametrised SIMD execution core: internal vector register file, LANES × LANE_W datapath, instruction issue over a valid/ready handshake.
- Single-cycle ALU ops write back on the accept edge.
- DIV runs on an iterative per-lane divider and stalls issue until it completes.
- Sits between the instruction sequencer and host load/store logic, replacing the fixed 4×32 ALU plus external register scaffolding.

Parameters:
- LANES, 4, number of SIMD lanes.
- LANE_W, 32, bits per lane; vector width VW = LANES*LANE_W.
- NREGS, 16, vector registers (≤ 32).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction present.
- instr  in  19  {opcode[18:15], src1[14:10], src2[9:5], dest[4:0]}.
- instr_ready  out  1  core can accept an instruction.
- host_we  in  1  host register write strobe.
- host_addr  in  5  host read/write register index.
- host_wdata  in  VW  host write data.
- host_rdata  out  VW  combinational read of RF[host_addr]; 0 if out of range.
- wb_valid  out  1  one-cycle pulse: a result was written.
- wb_dest  out  5  register written.
- wb_data  out  VW  value written.
- illegal  out  1  one-cycle pulse: rejected instruction.
- busy  out  1  divide in progress.

Behaviour:
- Lane packing: lane i occupies bits [(i+1)*LANE_W-1 : i*LANE_W]. All arithmetic is unsigned and per lane; there are no inter-lane carries.
- Opcodes and per-lane results:
  - 0 ADD, 1 SUB, 2 MUL: low LANE_W bits (modulo wrap).
  - 3 AND, 4 OR, 5 XOR, 6 NAND, 7 NOR, 8 XNOR: bitwise.
  - 9 DIV: quotient; divisor 0 gives all-ones.
  - 10 EQ, 11 GT, 12 LT: lane = 1 if true, else 0.
  - 13 NOP: no write, no wb_valid.
  - 14, 15: illegal.
- Accept rule: accept when instr_valid && instr_ready at a rising edge.
- instr_ready = (state == IDLE); it does not depend on instr_valid.
- Non-DIV op accepted at edge N:
  - Operands are read combinationally from the RF.
  - RF[dest] is written at edge N.
  - wb_valid/wb_dest/wb_data are registered at edge N and visible for cycle N..N+1.
  - Back-to-back dependent instructions therefore see the new value.
- DIV:
  - At the accept edge, latch operands and dest, start the divider, and move IDLE→DIV.
  - One quotient bit per lane per cycle; all lanes run in parallel.
  - After LANE_W cycles: write RF, pulse wb_valid, return DIV→IDLE. instr_ready rises the same cycle.
  - Total: RF written LANE_W edges after the accept edge.
  - busy = (state == DIV).
- Illegal instruction (opcode 14/15, or src1/src2/dest ≥ NREGS):
  - Accepted (consumes the handshake), with no RF write.
  - illegal pulses one cycle; wb_valid stays 0.
- Host write:
  - RF[host_addr] <= host_wdata on an edge with host_we, if host_addr < NREGS; otherwise ignored.
  - Same edge and same register as an instruction or DIV writeback: the writeback wins and the host write is dropped.
  - Host writes are allowed while busy.
  - A host write to a DIV source register during DIV does not affect the quotient, because operands are latched.
- Reset (asynchronous, any time, including mid-DIV):
  - state = IDLE, all RF entries 0, divider cleared; an in-flight DIV is aborted with no writeback.
  - Outputs: wb_valid 0, wb_dest 0, wb_data 0, illegal 0, busy 0, instr_ready 1 (after reset deasserts).

Decomposition:
- Package simd_pkg holds:
  - opcode localparams OP_ADD..OP_LT, OP_NOP, and the instruction field offsets;
  - state enum {IDLE, DIV}.
- Sub-module simd_lane_divider: one LANE_W restoring divider (start, dividend, divisor → quotient, done), instantiated LANES times with a generate loop.
- The combinational lane ALU lives inline in simd_vector_core.

Test Plan:
- Host loads R1 lanes {3:20, 2:15, 1:10, 0:5} and R2 {12, 9, 6, 3}; ADD R1,R2→R3 → wb_valid next cycle, R3 = {32, 24, 16, 8}. Then SUB→R4 = {8, 6, 4, 2}, MUL→R5 = {240, 135, 60, 15}.
- EQ/GT/LT R1,R2 → {0,0,0,0} / {1,1,1,1} / {0,0,0,0}; SUB R2,R1 → lane 3 = 0xFFFFFFF8 (wrap).
- DIV R1,R2→R12 → instr_ready low for exactly 32 cycles, busy high, then R12 = {1,1,1,1}. A second instr_valid held throughout is accepted only after completion.
- DIV by a register with lane 0 = 0 → that lane = 0xFFFFFFFF, other lanes correct.
- Back-to-back ADD R1,R2→R3 then ADD R3,R3→R6 → R6 = {64, 48, 32, 16}. Same-edge host write to R3 is dropped.
- Opcode 14, or dest = 20 with NREGS = 16 → illegal pulse, no RF change. Reset asserted mid-DIV → busy 0, no wb_valid, all registers 0.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared opcodes, instruction field layout and control state for the SIMD vector core.
package simd_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_NAND = 4'd6;
   localparam logic [3:0] OP_NOR  = 4'd7;
   localparam logic [3:0] OP_XNOR = 4'd8;
   localparam logic [3:0] OP_DIV  = 4'd9;
   localparam logic [3:0] OP_EQ   = 4'd10;
   localparam logic [3:0] OP_GT   = 4'd11;
   localparam logic [3:0] OP_LT   = 4'd12;
   localparam logic [3:0] OP_NOP  = 4'd13;
   localparam logic [3:0] OP_FIRST_ILLEGAL = 4'd14;

   localparam int OPC_LSB  = 15;
   localparam int SRC1_LSB = 10;
   localparam int SRC2_LSB = 5;
   localparam int DEST_LSB = 0;

   typedef enum logic {IDLE, DIV} state_t;

endpackage

// File: rtl/simd_lane_divider.sv
// One-lane unsigned restoring divider: one quotient bit per clock, LANE_W steps after start.
// done flags the edge that performs the final step; quotient is that step's result.
module simd_lane_divider #(
   parameter int LANE_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LANE_W-1:0] dividend,
   input  logic [LANE_W-1:0] divisor,
   output logic [LANE_W-1:0] quotient,
   output logic              done
);
   localparam int CW = $clog2(LANE_W + 1);

   logic [LANE_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [LANE_W:0]   rem_shift;
   logic [LANE_W-1:0] diff;
   logic              ge;

   // A zero divisor always compares as "fits", so the quotient saturates to all-ones.
   always_comb begin
      rem_shift = {rem_q, quo_q[LANE_W-1]};
      ge        = rem_shift >= {1'b0, dvs_q};
      diff      = rem_shift[LANE_W-1:0] - dvs_q;
      quotient  = {quo_q[LANE_W-2:0], ge};
      done      = (cnt_q == CW'(1));
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      if (start) begin
         rem_d = '0;
         quo_d = dividend;
         dvs_d = divisor;
         cnt_d = CW'(LANE_W);
      end else if (cnt_q != '0) begin
         rem_d = ge ? diff : rem_shift[LANE_W-1:0];
         quo_d = quotient;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/simd_vector_core.sv
// SIMD execution core: vector register file, per-lane ALU, iterative DIV that stalls issue.
// state | meaning:  IDLE | accepting instructions;  DIV | lane dividers running, issue stalled
module simd_vector_core
   import simd_pkg::*;
#(
   parameter  int LANES  = 4,
   parameter  int LANE_W = 32,
   parameter  int NREGS  = 16,
   localparam int VW     = LANES * LANE_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          instr_valid,
   input  logic [18:0]   instr,
   output logic          instr_ready,
   input  logic          host_we,
   input  logic [4:0]    host_addr,
   input  logic [VW-1:0] host_wdata,
   output logic [VW-1:0] host_rdata,
   output logic          wb_valid,
   output logic [4:0]    wb_dest,
   output logic [VW-1:0] wb_data,
   output logic          illegal,
   output logic          busy
);
   localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [5:0] NREGS_L = 6'(NREGS);

   state_t            state_q, state_d;
   logic [VW-1:0]     rf_q [NREGS];
   logic [VW-1:0]     rf_d [NREGS];
   logic              wb_valid_q, wb_valid_d, illegal_q, illegal_d;
   logic [4:0]        wb_dest_q, wb_dest_d, div_dest_q, div_dest_d;
   logic [VW-1:0]     wb_data_q, wb_data_d;
   logic [3:0]        opc;
   logic [4:0]        src1, src2, dest;
   logic [VW-1:0]     op_a, op_b, alu_res, div_quo;
   logic [LANES-1:0]  lane_done;
   logic              accept, bad_instr, div_start;

   function automatic logic [LANE_W-1:0] lane_alu(input logic [3:0] op,
                                                  input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b);
      case (op)
         OP_ADD:  lane_alu = a + b;
         OP_SUB:  lane_alu = a - b;
         OP_MUL:  lane_alu = a * b;
         OP_AND:  lane_alu = a & b;
         OP_OR:   lane_alu = a | b;
         OP_XOR:  lane_alu = a ^ b;
         OP_NAND: lane_alu = ~(a & b);
         OP_NOR:  lane_alu = ~(a | b);
         OP_XNOR: lane_alu = ~(a ^ b);
         OP_EQ:   lane_alu = LANE_W'(a == b);
         OP_GT:   lane_alu = LANE_W'(a > b);
         OP_LT:   lane_alu = LANE_W'(a < b);
         default: lane_alu = '0;
      endcase
   endfunction

   assign opc  = instr[OPC_LSB  +: 4];
   assign src1 = instr[SRC1_LSB +: 5];
   assign src2 = instr[SRC2_LSB +: 5];
   assign dest = instr[DEST_LSB +: 5];

   // Out-of-range indices only alias here; such instructions are rejected before use.
   assign op_a      = rf_q[src1[AW-1:0]];
   assign op_b      = rf_q[src2[AW-1:0]];
   assign bad_instr = (opc >= OP_FIRST_ILLEGAL) || ({1'b0, src1} >= NREGS_L) ||
                      ({1'b0, src2} >= NREGS_L) || ({1'b0, dest} >= NREGS_L);
   assign accept    = instr_valid && (state_q == IDLE);

   always_comb begin
      alu_res = '0;
      for (int i = 0; i < LANES; i++)
         alu_res[i*LANE_W +: LANE_W] = lane_alu(opc, op_a[i*LANE_W +: LANE_W],
                                                op_b[i*LANE_W +: LANE_W]);
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      simd_lane_divider #(.LANE_W(LANE_W)) u_div (
         .clk      (clk),
         .reset    (reset),
         .start    (div_start),
         .dividend (op_a[i*LANE_W +: LANE_W]),
         .divisor  (op_b[i*LANE_W +: LANE_W]),
         .quotient (div_quo[i*LANE_W +: LANE_W]),
         .done     (lane_done[i])
      );
   end

   // Host write is applied first so a same-edge core writeback to that register overrides it.
   always_comb begin
      rf_d       = rf_q;
      state_d    = state_q;
      wb_valid_d = 1'b0;
      wb_dest_d  = wb_dest_q;
      wb_data_d  = wb_data_q;
      illegal_d  = 1'b0;
      div_dest_d = div_dest_q;
      div_start  = 1'b0;
      if (host_we && ({1'b0, host_addr} < NREGS_L))
         rf_d[host_addr[AW-1:0]] = host_wdata;
      if (state_q == IDLE) begin
         if (accept) begin
            if (bad_instr) begin
               illegal_d = 1'b1;
            end else if (opc == OP_DIV) begin
               div_start  = 1'b1;
               div_dest_d = dest;
               state_d    = DIV;
            end else if (opc != OP_NOP) begin
               rf_d[dest[AW-1:0]] = alu_res;
               wb_valid_d         = 1'b1;
               wb_dest_d          = dest;
               wb_data_d          = alu_res;
            end
         end
      end else if (&lane_done) begin
         rf_d[div_dest_q[AW-1:0]] = div_quo;
         wb_valid_d               = 1'b1;
         wb_dest_d                = div_dest_q;
         wb_data_d                = div_quo;
         state_d                  = IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wb_valid_q <= 1'b0;
         wb_dest_q  <= '0;
         wb_data_q  <= '0;
         illegal_q  <= 1'b0;
         div_dest_q <= '0;
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         wb_valid_q <= wb_valid_d;
         wb_dest_q  <= wb_dest_d;
         wb_data_q  <= wb_data_d;
         illegal_q  <= illegal_d;
         div_dest_q <= div_dest_d;
         rf_q       <= rf_d;
      end
   end

   assign instr_ready = (state_q == IDLE);
   assign busy        = (state_q == DIV);
   assign wb_valid    = wb_valid_q;
   assign wb_dest     = wb_dest_q;
   assign wb_data     = wb_data_q;
   assign illegal     = illegal_q;
   assign host_rdata  = ({1'b0, host_addr} < NREGS_L) ? rf_q[host_addr[AW-1:0]] : '0;

endmodule
